// File: rtl/harmonic_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : harmonic_engine                                                 |
// | Brief  : Additive-synthesis core. On each sample tick it walks up to N   |
// |          harmonics of a fundamental, advances each harmonic's stored     |
// |          phase, looks up an external sine LUT and sums the scaled taps.  |
// |          Amplitude decays linearly per harmonic; harmonics at or above   |
// |          Nyquist end the frame early.                                    |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module harmonic_engine #(
  parameter int NUM_HARMONICS = 64,
  parameter int PHASE_BITS    = 24,
  parameter int LUT_ADDR_BITS = 11,
  parameter int LUT_LATENCY   = 2,
  parameter int ACC_BITS      = 32,
  parameter int OUT_BITS      = 16,
  parameter int OUT_SHIFT     = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        sample_tick_i,
  input  logic [PHASE_BITS-1:0]       frequency_i,
  input  logic [7:0]                  harmonic_cnt_i,
  input  logic                        odd_only_i,
  input  logic [6:0]                  decay_i,
  output logic [LUT_ADDR_BITS-1:0]    lut_addr_o,
  input  logic signed [15:0]          lut_data_i,
  output logic signed [OUT_BITS-1:0]  sample_out_o,
  output logic                        sample_valid_o,
  output logic                        busy_o,
  output logic                        overrun_o
);

  // Harmonic count is carried in 8 bits, so the RAM depth must not exceed 255.
  localparam int IDX_W  = (NUM_HARMONICS > 1) ? $clog2(NUM_HARMONICS) : 1;
  localparam int INC_W  = PHASE_BITS + 2;  // holds inc below Nyquist plus one 2*f step
  localparam int WAIT_W = (LUT_LATENCY > 1) ? $clog2(LUT_LATENCY + 1) : 1;
  localparam int PROD_W = 25;

  localparam logic [7:0]       MAX_CNT  = 8'(NUM_HARMONICS);
  localparam logic [INC_W-1:0] NYQ      = INC_W'(1) << (PHASE_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_HARMONICS - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(LUT_LATENCY - 1);
  localparam logic signed [ACC_BITS-1:0] OUT_MAX =
    {{(ACC_BITS-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
  localparam logic signed [ACC_BITS-1:0] OUT_MIN =
    {{(ACC_BITS-OUT_BITS+1){1'b1}}, {(OUT_BITS-1){1'b0}}};

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_READ  = 3'd2,
    S_UPD   = 3'd3,
    S_WAIT  = 3'd4,
    S_MAC   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t                      state_q;
  logic [IDX_W-1:0]            clr_idx_q;
  logic [7:0]                  k_q;
  logic [7:0]                  cnt_q;
  logic                        odd_q;
  logic [6:0]                  decay_q;
  logic [PHASE_BITS-1:0]       freq_q;
  logic [INC_W-1:0]            inc_q;
  logic [7:0]                  amp_q;
  logic signed [ACC_BITS-1:0]  acc_q;
  logic [WAIT_W-1:0]           wait_q;
  logic [LUT_ADDR_BITS-1:0]    lut_addr_q;
  logic signed [OUT_BITS-1:0]  sample_q;
  logic                        valid_q;
  logic                        busy_q;
  logic                        overrun_q;

  // Phase RAM: one accumulator per harmonic slot, synchronous read.
  logic [PHASE_BITS-1:0]       phase_ram [NUM_HARMONICS];
  logic [PHASE_BITS-1:0]       rdata_q;

  logic [7:0]                  cnt_clamp_d;
  logic [INC_W-1:0]            step_d;
  logic [INC_W-1:0]            inc_d;
  logic [7:0]                  amp_d;
  logic [7:0]                  k_d;
  logic [PHASE_BITS-1:0]       phase_d;
  logic signed [PROD_W-1:0]    prod_d;
  logic signed [ACC_BITS-1:0]  acc_d;
  logic                        stop_d;
  logic signed [ACC_BITS-1:0]  shifted_d;
  logic signed [OUT_BITS-1:0]  sample_d;
  logic                        ram_we_d;
  logic [IDX_W-1:0]            ram_waddr_d;
  logic [PHASE_BITS-1:0]       ram_wdata_d;

  assign cnt_clamp_d = (harmonic_cnt_i > MAX_CNT) ? MAX_CNT : harmonic_cnt_i;
  assign step_d      = odd_q ? {1'b0, freq_q, 1'b0} : {2'b00, freq_q};
  assign inc_d       = inc_q + step_d;
  assign amp_d       = (amp_q > {1'b0, decay_q}) ? (amp_q - {1'b0, decay_q}) : 8'd0;
  assign k_d         = k_q + 8'd1;
  assign phase_d     = rdata_q + inc_q[PHASE_BITS-1:0];
  // Signed LUT sample times unsigned amplitude, both widened to the product width.
  assign prod_d      = $signed({{(PROD_W-16){lut_data_i[15]}}, lut_data_i})
                     * $signed({{(PROD_W-8){1'b0}}, amp_q});
  assign acc_d       = acc_q + {{(ACC_BITS-PROD_W){prod_d[PROD_W-1]}}, prod_d};
  // inc is compared at full width so a wrapped phase step can never look sub-Nyquist.
  assign stop_d      = (k_d == cnt_q) || (amp_d == 8'd0) || (inc_d >= NYQ);
  // /128 removes the amplitude scale, OUT_SHIFT adds headroom.
  assign shifted_d   = acc_q >>> (7 + OUT_SHIFT);
  assign sample_d    = (shifted_d > OUT_MAX) ? OUT_MAX[OUT_BITS-1:0] :
                       (shifted_d < OUT_MIN) ? OUT_MIN[OUT_BITS-1:0] :
                                               shifted_d[OUT_BITS-1:0];

  assign ram_we_d    = (state_q == S_CLEAR) || (state_q == S_UPD);
  assign ram_waddr_d = (state_q == S_CLEAR) ? clr_idx_q : k_q[IDX_W-1:0];
  assign ram_wdata_d = (state_q == S_CLEAR) ? '0 : phase_d;

  // Phase RAM write port (clear sweep or phase write-back) and registered read.
  always_ff @(posedge clk_i) begin
    if (ram_we_d) begin
      phase_ram[ram_waddr_d] <= ram_wdata_d;
    end
    if (state_q == S_READ) begin
      rdata_q <= phase_ram[k_q[IDX_W-1:0]];
    end
  end

  // Frame sequencer: clear sweep, per-harmonic read/update/wait/MAC, output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_CLEAR;
      clr_idx_q  <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      odd_q      <= 1'b0;
      decay_q    <= '0;
      freq_q     <= '0;
      inc_q      <= '0;
      amp_q      <= '0;
      acc_q      <= '0;
      wait_q     <= '0;
      lut_addr_q <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b1;
      overrun_q  <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      // Any tick outside IDLE is dropped; CLEAR swallows ticks silently.
      overrun_q <= sample_tick_i && (state_q != S_IDLE) && (state_q != S_CLEAR);
      case (state_q)
        S_CLEAR: begin
          clr_idx_q <= clr_idx_q + 1'b1;
          if (clr_idx_q == LAST_IDX) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (sample_tick_i) begin
            cnt_q   <= cnt_clamp_d;
            odd_q   <= odd_only_i;
            decay_q <= decay_i;
            freq_q  <= frequency_i;
            inc_q   <= {2'b00, frequency_i};
            amp_q   <= 8'd127;
            acc_q   <= '0;
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= (cnt_clamp_d == 8'd0) ? S_DONE : S_READ;
          end
        end
        S_READ: begin
          state_q <= S_UPD;
        end
        S_UPD: begin
          lut_addr_q <= phase_d[PHASE_BITS-1 -: LUT_ADDR_BITS];
          wait_q     <= '0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          wait_q <= wait_q + 1'b1;
          if (wait_q == LAST_WAIT) begin
            state_q <= S_MAC;
          end
        end
        S_MAC: begin
          acc_q   <= acc_d;
          k_q     <= k_d;
          inc_q   <= inc_d;
          amp_q   <= amp_d;
          state_q <= stop_d ? S_DONE : S_READ;
        end
        S_DONE: begin
          sample_q <= sample_d;
          valid_q  <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          state_q   <= S_CLEAR;
          clr_idx_q <= '0;
          busy_q    <= 1'b1;
        end
      endcase
    end
  end

  assign lut_addr_o     = lut_addr_q;
  assign sample_out_o   = sample_q;
  assign sample_valid_o = valid_q;
  assign busy_o         = busy_q;
  assign overrun_o      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_harmonic_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_harmonic_engine                                              |
// | Brief  : Self-checking bench for harmonic_engine with an external LUT    |
// |          model and an arithmetic reference of the frame sum.             |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_harmonic_engine;
  localparam int N = 64;
  localparam int P = 24;
  localparam int A = 11;
  localparam int L = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               tick;
  logic [P-1:0]       freq;
  logic [7:0]         hcnt;
  logic               odd;
  logic [6:0]         decay;
  logic [A-1:0]       lut_addr;
  logic signed [15:0] lut_data;
  logic signed [15:0] sample;
  logic               valid;
  logic               busy;
  logic               overrun;

  int errors = 0;
  int checks = 0;
  int lut_mode = 0;
  int lut_const = 0;
  int exp_addr = 0;
  longint model_phase [N];

  always #5 clk = ~clk;

  harmonic_engine dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .sample_tick_i  (tick),
    .frequency_i    (freq),
    .harmonic_cnt_i (hcnt),
    .odd_only_i     (odd),
    .decay_i        (decay),
    .lut_addr_o     (lut_addr),
    .lut_data_i     (lut_data),
    .sample_out_o   (sample),
    .sample_valid_o (valid),
    .busy_o         (busy),
    .overrun_o      (overrun)
  );

  // External sine LUT stand-in: L-stage address pipeline, content chosen by mode.
  function automatic int lut_fn(input int mode, input int cval, input int a);
    logic [15:0] t;
    case (mode)
      0:       return a;
      1:       return cval;
      default: begin
        t = 16'(a * 40503 + 12345);
        return int'($signed(t));
      end
    endcase
  endfunction

  logic [A-1:0] st1, st2;
  always @(posedge clk) begin
    st1 <= lut_addr;
    st2 <= st1;
  end
  assign lut_data = 16'(lut_fn(lut_mode, lut_const, int'(st2)));

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference frame: harmonic i uses multiplier m and amplitude 127-i*decay.
  task automatic model_frame(input int cnt, input int od, input int f, input int dec,
                             output int h, output int exp_s);
    int     cc, m, amp, addr;
    longint sum, sh;
    cc = (cnt > N) ? N : cnt;
    h = 0;
    sum = 0;
    for (int i = 0; i < cc; i++) begin
      m   = od ? 2 * i + 1 : i + 1;
      amp = 127 - i * dec;
      if (i > 0 && (amp <= 0 || longint'(m) * f >= (longint'(1) << (P - 1)))) break;
      model_phase[i] = (model_phase[i] + longint'(m) * f) % (longint'(1) << P);
      addr = int'(model_phase[i] >> (P - A));
      sum += longint'(lut_fn(lut_mode, lut_const, addr)) * amp;
      exp_addr = addr;
      h++;
    end
    sh = sum >>> 9;
    exp_s = (sh > 32767) ? 32767 : (sh < -32768) ? -32768 : int'(sh);
  endtask

  task automatic clear_wait();
    int n;
    bit ov;
    n = 0;
    ov = 0;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (n == 10) tick = 1'b1;
      if (n == 11) tick = 1'b0;
      if (overrun || valid) ov = 1;
      if (!busy) break;
    end
    chk("clear_len", n, 64);
    chk("clear_ignores_tick", ov, 0);
    for (int i = 0; i < N; i++) model_phase[i] = 0;
    exp_addr = 0;
  endtask

  // Caller is at #1 after a posedge. inject>0 puts a tick at that cycle count,
  // inject<0 puts it on the DONE cycle.
  task automatic run_frame(input int cnt, input int od, input int f, input int dec,
                           input int inject_in, input bit b2b);
    int h, exp_s, lat, n, inject;
    bit done;
    model_frame(cnt, od, f, dec, h, exp_s);
    lat = 2 + h * (3 + L);
    inject = (inject_in < 0) ? lat - 1 : inject_in;
    if (inject < 2 || inject >= lat) inject = 0;
    hcnt = 8'(cnt); odd = od[0]; freq = P'(f); decay = 7'(dec);
    tick = 1'b1;
    n = 0;
    done = 0;
    while (!done && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        tick = 1'b0;
        freq = P'($urandom); hcnt = 8'($urandom); odd = 1'($urandom); decay = 7'($urandom);
        chk("busy_in_frame", busy, 1);
      end
      if (inject > 0 && n == inject + 1) begin
        chk("overrun_pulse", overrun, 1);
        tick = 1'b0;
      end
      if (inject > 0 && n == inject + 2) chk("overrun_end", overrun, 0);
      if (inject > 0 && n == inject) tick = 1'b1;
      if (valid) done = 1;
    end
    tick = 1'b0;
    chk("latency", n, lat);
    chk("sample", sample, exp_s);
    chk("lut_addr", lut_addr, exp_addr);
    if (!b2b) begin
      @(posedge clk); #1;
      chk("valid_pulse", valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_overrun", overrun, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, od, f, dec, inj, cls;
    rst_n = 1'b0; tick = 1'b0; freq = '0; hcnt = '0; odd = 1'b0; decay = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sample", sample, 0);
    chk("rst_valid", valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_addr", lut_addr, 0);
    chk("rst_busy", busy, 1);
    @(negedge clk);
    rst_n = 1'b1;
    clear_wait();

    // zero harmonics
    run_frame(0, 0, 0, 0, 0, 0);
    // single harmonic, LUT returns its address
    lut_mode = 0;
    run_frame(1, 0, 8192, 0, 0, 0);
    run_frame(1, 0, 8192, 0, 0, 1);
    run_frame(1, 0, 8192, 0, 0, 0);
    run_frame(3, 0, 1 << 20, 0, 0, 0);
    // Nyquist cut, then a frame that exposes untouched entries
    lut_mode = 2;
    run_frame(8, 0, 'h300000, 0, 0, 0);
    run_frame(8, 0, 'h010000, 3, 0, 0);
    // saturation and decay cut-off
    lut_mode = 1;
    lut_const = 32767;
    run_frame(64, 0, 1, 0, 0, 0);
    lut_const = -32768;
    run_frame(200, 1, 1, 0, 0, 0);
    lut_const = 1000;
    run_frame(64, 0, 5, 64, 0, 0);
    // overrun mid-frame and on the DONE cycle
    lut_mode = 2;
    run_frame(6, 1, 12345, 5, 7, 0);
    run_frame(6, 0, 54321, 2, -1, 0);

    for (int r = 0; r < 25; r++) begin
      lut_mode = int'($urandom_range(0, 2));
      lut_const = int'($urandom_range(0, 65535)) - 32768;
      cnt = int'($urandom_range(0, 72));
      od  = int'($urandom_range(0, 1));
      cls = int'($urandom_range(0, 2));
      f   = (cls == 0) ? int'($urandom_range(0, 4095)) :
            (cls == 1) ? int'($urandom_range(0, 1 << 18)) : int'($urandom & 32'hFFFFFF);
      dec = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 127));
      inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 20)) : 0;
      run_frame(cnt, od, f, dec, inj, 1'($urandom_range(0, 1)));
    end

    // reset in the middle of a frame
    lut_mode = 1;
    lut_const = 20000;
    run_frame(4, 0, 100, 0, 0, 0);
    hcnt = 8'd10; odd = 1'b0; freq = P'(777); decay = '0;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_sample", sample, 0);
    chk("midrst_busy", busy, 1);
    chk("midrst_addr", lut_addr, 0);
    chk("midrst_valid", valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_wait();

    // odd harmonics from fresh phases: addresses 1,3,5,7 then 2,6,10,14
    lut_mode = 0;
    run_frame(4, 1, 8192, 0, 0, 0);
    chk("odd_first_last_addr", lut_addr, 7);
    run_frame(4, 1, 8192, 0, 0, 0);
    chk("odd_second_last_addr", lut_addr, 14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
